// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fp_pkg
// Purpose  : Shared single-precision constants, field helpers and the
//            prepared-operand record handed from the pre-align stage to the adder.
// Revision : 1.0
// ============================================================================
package fp_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int GRS_W = 3;
    localparam int BIAS  = 127;
    localparam int SIG_W = MAN_W + 1 + GRS_W;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [SIG_W-1:0]  man_a;
        logic [SIG_W-1:0]  man_b;
        logic              eff_sub;
        logic              special;
        logic [31:0]       special_result;
    } prep_t;

    // Stage-1 record: the small mantissa is still unshifted
    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [EXP_W-1:0]  exp_diff;
        logic [SIG_W-1:0]  man_a;
        logic [SIG_W-1:0]  man_s;
        logic              eff_sub;
        logic              special;
        logic [31:0]       special_result;
    } s1_t;

    function automatic logic f_sign(input logic [31:0] x);
        return x[31];
    endfunction

    function automatic logic [EXP_W-1:0] f_exp(input logic [31:0] x);
        return x[30:23];
    endfunction

    function automatic logic [MAN_W-1:0] f_frac(input logic [31:0] x);
        return x[22:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp_addsub_prealign_if.sv
`default_nettype none
// ============================================================================
// Module   : fp_addsub_prealign_if
// Purpose  : Operand-in / prepared-operand-out handshake bundle.
// Revision : 1.0
// ============================================================================
interface fp_addsub_prealign_if;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] number1;
    logic [31:0] number2;
    logic        op;
    logic        out_valid;
    logic        out_ready;
    logic        out_sign;
    logic [7:0]  out_exp;
    logic [26:0] out_man_a;
    logic [26:0] out_man_b;
    logic        out_eff_sub;
    logic        out_special;
    logic [31:0] out_special_result;

    modport master (
        output in_valid, number1, number2, op, out_ready,
        input  in_ready, out_valid, out_sign, out_exp, out_man_a, out_man_b,
               out_eff_sub, out_special, out_special_result
    );

    modport slave (
        input  in_valid, number1, number2, op, out_ready,
        output in_ready, out_valid, out_sign, out_exp, out_man_a, out_man_b,
               out_eff_sub, out_special, out_special_result
    );

endinterface
`default_nettype wire

// File: rtl/fp_align_shifter.sv
`default_nettype none
// ============================================================================
// Module   : fp_align_shifter
// Purpose  : Combinational right shifter folding every shifted-out bit into
//            a sticky OR at bit 0.
// Revision : 1.0
// ============================================================================
module fp_align_shifter #(
    parameter int WIDTH   = 27,
    parameter int SHIFT_W = 8
) (
    input  wire logic [WIDTH-1:0]   i_din,
    input  wire logic [SHIFT_W-1:0] i_shamt,
    output logic      [WIDTH-1:0]   o_dout
);

    logic [WIDTH-1:0] w_shifted;
    logic [WIDTH-1:0] w_lost_mask;

    always_comb begin
        w_shifted   = '0;
        w_lost_mask = '0;
        if (i_shamt >= SHIFT_W'(WIDTH)) begin
            o_dout = {{(WIDTH-1){1'b0}}, |i_din};
        end else begin
            w_shifted   = i_din >> i_shamt;
            w_lost_mask = ~({WIDTH{1'b1}} << i_shamt);
            o_dout      = {w_shifted[WIDTH-1:1], w_shifted[0] | (|(i_din & w_lost_mask))};
        end
    end

endmodule
`default_nettype wire

// File: rtl/fp_addsub_prealign.sv
`default_nettype none
// ============================================================================
// Module   : fp_addsub_prealign
// Purpose  : Two-stage unpack/classify/swap then align pipeline feeding the
//            mantissa adder, with valid/ready on both sides.
// Revision : 1.0
// ============================================================================
module fp_addsub_prealign #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int GRS_W = 3
) (
    input  wire logic              clk,
    input  wire logic              rst,
    fp_addsub_prealign_if.slave    bus
);
    import fp_pkg::*;

    localparam int SIG_W_L = MAN_W + 1 + GRS_W;

    logic               w_en1, w_en2;
    logic               r_v1, r_v2;
    s1_t                r_s1, w_s1;
    prep_t              r_p, w_p;

    logic               w_a_sign, w_b_sign, w_swap, w_eff_sub;
    logic [EXP_W-1:0]   w_a_exp, w_b_exp, w_a_exp_eff, w_b_exp_eff;
    logic [MAN_W-1:0]   w_a_frac, w_b_frac;
    logic [SIG_W_L-1:0] w_a_man, w_b_man, w_man_b_aligned;
    logic               w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;

    assign w_en2        = !r_v2 || bus.out_ready;
    assign w_en1        = !r_v1 || w_en2;
    assign bus.in_ready = w_en1;

    // Stage 1: unpack, classify and order by magnitude
    always_comb begin
        w_a_sign    = f_sign(bus.number1);
        w_b_sign    = f_sign(bus.number2) ^ bus.op;
        w_a_exp     = f_exp(bus.number1);
        w_b_exp     = f_exp(bus.number2);
        w_a_frac    = f_frac(bus.number1);
        w_b_frac    = f_frac(bus.number2);
        w_a_exp_eff = (w_a_exp == '0) ? EXP_W'(1) : w_a_exp;
        w_b_exp_eff = (w_b_exp == '0) ? EXP_W'(1) : w_b_exp;
        w_a_man     = {(w_a_exp != '0), w_a_frac, {GRS_W{1'b0}}};
        w_b_man     = {(w_b_exp != '0), w_b_frac, {GRS_W{1'b0}}};
        w_a_nan     = (&w_a_exp) && (w_a_frac != '0);
        w_b_nan     = (&w_b_exp) && (w_b_frac != '0);
        w_a_inf     = (&w_a_exp) && (w_a_frac == '0);
        w_b_inf     = (&w_b_exp) && (w_b_frac == '0);
        w_a_zero    = (w_a_exp == '0) && (w_a_frac == '0);
        w_b_zero    = (w_b_exp == '0) && (w_b_frac == '0);
        w_swap      = bus.number2[30:0] > bus.number1[30:0];
        w_eff_sub   = w_a_sign ^ w_b_sign;

        w_s1         = '0;
        w_s1.eff_sub = w_eff_sub;
        if (w_swap) begin
            w_s1.sign     = w_b_sign;
            w_s1.exp      = w_b_exp_eff;
            w_s1.exp_diff = w_b_exp_eff - w_a_exp_eff;
            w_s1.man_a    = w_b_man;
            w_s1.man_s    = w_a_man;
        end else begin
            w_s1.sign     = w_a_sign;
            w_s1.exp      = w_a_exp_eff;
            w_s1.exp_diff = w_a_exp_eff - w_b_exp_eff;
            w_s1.man_a    = w_a_man;
            w_s1.man_s    = w_b_man;
        end

        w_s1.special = 1'b1;
        if (w_a_nan || w_b_nan) begin
            w_s1.special_result = QNAN;
        end else if (w_a_inf && w_b_inf && w_eff_sub) begin
            w_s1.special_result = QNAN;
        end else if (w_a_inf) begin
            w_s1.special_result = POS_INF | {w_a_sign, 31'b0};
        end else if (w_b_inf) begin
            w_s1.special_result = POS_INF | {w_b_sign, 31'b0};
        end else if (w_a_zero && w_b_zero) begin
            w_s1.special_result = {w_a_sign & w_b_sign, 31'b0};
        end else begin
            w_s1.special        = 1'b0;
            w_s1.special_result = '0;
        end
    end

    fp_align_shifter #(
        .WIDTH   (SIG_W_L),
        .SHIFT_W (EXP_W)
    ) u_align (
        .i_din   (r_s1.man_s),
        .i_shamt (r_s1.exp_diff),
        .o_dout  (w_man_b_aligned)
    );

    // Stage 2: align the smaller mantissa, everything else passes through
    always_comb begin
        w_p                = '0;
        w_p.sign           = r_s1.sign;
        w_p.exp            = r_s1.exp;
        w_p.man_a          = r_s1.man_a;
        w_p.man_b          = w_man_b_aligned;
        w_p.eff_sub        = r_s1.eff_sub;
        w_p.special        = r_s1.special;
        w_p.special_result = r_s1.special_result;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            r_s1 <= '0;
            r_p  <= '0;
        end else begin
            if (w_en1) begin
                r_v1 <= bus.in_valid;
                if (bus.in_valid) begin
                    r_s1 <= w_s1;
                end
            end
            if (w_en2) begin
                r_v2 <= r_v1;
                if (r_v1) begin
                    r_p <= w_p;
                end
            end
        end
    end

    assign bus.out_valid          = r_v2;
    assign bus.out_sign           = r_p.sign;
    assign bus.out_exp            = r_p.exp;
    assign bus.out_man_a          = r_p.man_a;
    assign bus.out_man_b          = r_p.man_b;
    assign bus.out_eff_sub        = r_p.eff_sub;
    assign bus.out_special        = r_p.special;
    assign bus.out_special_result = r_p.special_result;

endmodule
`default_nettype wire
